// File: rtl/ahb_req_pkg.sv
// Shared types and constants for the per-master AHB bus-request front end.
package ahb_req_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    // Prefixed so the state names do not collide with the HTRANS encodings.
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_DATA
    } req_state_t;

    localparam int MAX_BEATS = 16;

    function automatic logic [4:0] decode_beats(input logic [3:0] enc);
        return (enc == 4'd0) ? 5'(MAX_BEATS) : {1'b0, enc};
    endfunction

endpackage

// File: rtl/ahb_master_req_ctrl.sv
// Per-master request front end: HBUSREQ/HLOCK generation and HTRANS sequencing.
// Optional grant-wait timeout is built when AHB_REQ_TIMEOUT_EN is defined.
module ahb_master_req_ctrl
    import ahb_req_pkg::*;
#(
    parameter int unsigned MASTER_ID = 0,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_beats,
    input  logic       cmd_lock,
    output logic       HBUSREQ,
    output logic       HLOCK,
    input  logic       HGRANT,
    input  logic       HREADY,
    input  logic [3:0] HMASTER,
    output logic [1:0] HTRANS,
    output logic       beat_done,
    output logic       burst_done,
    output logic       protocol_err,
    output logic       timeout
);

    localparam logic [3:0] LP_MASTER = 4'(MASTER_ID);

    if (MASTER_ID > 15 || TIMEOUT == 0) begin : g_param_check
        $error("ahb_master_req_ctrl: MASTER_ID must be 0..15 and TIMEOUT nonzero");
    end

    req_state_t r_state, w_state_nxt;
    logic [4:0] r_remaining, w_remaining_nxt;
    logic [4:0] w_remaining_dec;
    logic       r_lock, w_lock_nxt;
    logic       r_first, w_first_nxt;
    logic       r_beat_done, w_beat_done_nxt;
    logic       r_burst_done, w_burst_done_nxt;
    logic       r_protocol_err, w_protocol_err_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic       w_wait_expired;
    logic       w_owning;
    htrans_t    w_htrans;

`ifdef AHB_REQ_TIMEOUT_EN
    localparam int unsigned LP_TO_W = $clog2(TIMEOUT + 1);
    logic [LP_TO_W-1:0] r_wait_cnt;

    assign w_wait_expired = (r_state == S_REQ) && (r_wait_cnt == LP_TO_W'(TIMEOUT - 1));

    // Counts consecutive REQ cycles; cleared on any exit, including ADDR->REQ re-arbitration.
    always_ff @(posedge HCLK) begin
        if (HRESET || (r_state != S_REQ) || (w_state_nxt != S_REQ)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_wait_expired = 1'b0;
`endif

    assign w_remaining_dec = r_remaining - 5'd1;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt        = r_state;
        w_remaining_nxt    = r_remaining;
        w_lock_nxt         = r_lock;
        w_first_nxt        = r_first;
        w_beat_done_nxt    = 1'b0;
        w_burst_done_nxt   = 1'b0;
        w_protocol_err_nxt = 1'b0;
        w_timeout_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_remaining_nxt = decode_beats(cmd_beats);
                    w_lock_nxt      = cmd_lock;
                    w_first_nxt     = 1'b1;
                    w_state_nxt     = S_REQ;
                end
            end
            S_REQ: begin
                if (HGRANT && HREADY) begin
                    w_state_nxt = S_ADDR;
                end else if (w_wait_expired) begin
                    w_state_nxt     = S_IDLE;
                    w_remaining_nxt = 5'd0;
                    w_lock_nxt      = 1'b0;
                    w_timeout_nxt   = 1'b1;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    w_beat_done_nxt    = 1'b1;
                    w_protocol_err_nxt = (HMASTER != LP_MASTER);
                    w_remaining_nxt    = w_remaining_dec;
                    w_first_nxt        = 1'b0;
                    if (w_remaining_dec == 5'd0) begin
                        w_state_nxt = S_DATA;
                    end else if (!HGRANT) begin
                        // Lost the bus mid-burst: the resumed beat must restart with NONSEQ.
                        w_state_nxt = S_REQ;
                        w_first_nxt = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    w_burst_done_nxt = 1'b1;
                    w_lock_nxt       = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state        <= S_IDLE;
            r_remaining    <= 5'd0;
            r_lock         <= 1'b0;
            r_first        <= 1'b0;
            r_beat_done    <= 1'b0;
            r_burst_done   <= 1'b0;
            r_protocol_err <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_remaining    <= w_remaining_nxt;
            r_lock         <= w_lock_nxt;
            r_first        <= w_first_nxt;
            r_beat_done    <= w_beat_done_nxt;
            r_burst_done   <= w_burst_done_nxt;
            r_protocol_err <= w_protocol_err_nxt;
            r_timeout      <= w_timeout_nxt;
        end
    end

    assign w_owning = (r_state == S_REQ) || (r_state == S_ADDR);
    assign w_htrans = (r_state == S_ADDR) ? (r_first ? NONSEQ : SEQ) : IDLE;

    assign cmd_ready    = (r_state == S_IDLE);
    assign HBUSREQ      = w_owning;
    assign HLOCK        = w_owning && r_lock;
    assign HTRANS       = w_htrans;
    assign beat_done    = r_beat_done;
    assign burst_done   = r_burst_done;
    assign protocol_err = r_protocol_err;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Scoreboard bench for ahb_master_req_ctrl: stimulus queues bursts, a negedge monitor
// predicts the bus-level response cycle by cycle from the protocol rules.
module tb_ahb_master_req_ctrl;

    localparam int ID = 5;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_beats;
    logic       cmd_lock;
    logic       HBUSREQ;
    logic       HLOCK;
    logic       HGRANT;
    logic       HREADY;
    logic [3:0] HMASTER;
    logic [1:0] HTRANS;
    logic       beat_done;
    logic       burst_done;
    logic       protocol_err;
    logic       timeout;

    ahb_master_req_ctrl #(.MASTER_ID(ID), .TIMEOUT(64)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_beats(cmd_beats), .cmd_lock(cmd_lock),
        .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HGRANT(HGRANT), .HREADY(HREADY), .HMASTER(HMASTER),
        .HTRANS(HTRANS),
        .beat_done(beat_done), .burst_done(burst_done),
        .protocol_err(protocol_err), .timeout(timeout)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- bus environment (arbiter side) ----------------
    bit         env_rand  = 1'b0;
    bit         env_lock  = 1'b0;
    int         grant_pct = 100;
    int         ready_pct = 100;
    int         wrong_pct = 0;
    bit         fix_grant = 1'b1;
    bit         fix_ready = 1'b1;
    logic [3:0] fix_master = 4'(ID);

    initial begin
        HGRANT  = 1'b0;
        HREADY  = 1'b1;
        HMASTER = 4'(ID);
        forever begin
            @(posedge HCLK);
            #2;
            if (env_rand) begin
                HGRANT  = env_lock ? 1'b1 : (int'($urandom_range(99)) < grant_pct);
                HREADY  = (int'($urandom_range(99)) < ready_pct);
                HMASTER = (int'($urandom_range(99)) < wrong_pct) ?
                          4'((ID + 1 + int'($urandom_range(14))) % 16) : 4'(ID);
            end else begin
                HGRANT  = fix_grant;
                HREADY  = fix_ready;
                HMASTER = fix_master;
            end
        end
    end

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        int beats;
        bit lock;
    } burst_t;

    burst_t     exp_q[$];
    burst_t     cur;
    bit         mon_en = 1'b0;
    bit         active, data_ph, exp_bd, exp_pe, exp_done, exp_req;
    logic [1:0] exp_tr;
    int         n_addr, n_bd, n_pe, n_pe_exp;

    function automatic bit mon_busy();
        return active || exp_done || (exp_q.size() > 0);
    endfunction

    task automatic mon_reset();
        exp_q.delete();
        active   = 1'b0;
        data_ph  = 1'b0;
        exp_bd   = 1'b0;
        exp_pe   = 1'b0;
        exp_done = 1'b0;
        exp_req  = 1'b0;
        exp_tr   = 2'b00;
    endtask

    task automatic mon_cycle();
        check("beat_done", 32'(beat_done), 32'(exp_bd));
        check("protocol_err", 32'(protocol_err), 32'(exp_pe));
        check("burst_done", 32'(burst_done), 32'(exp_done));
        check("timeout idle", 32'(timeout), 32'(0));
        if (beat_done)    n_bd++;
        if (protocol_err) n_pe++;
        if (exp_done) begin
            check("address phases per burst", 32'(n_addr), 32'(cur.beats));
            check("beat_done pulses per burst", 32'(n_bd), 32'(cur.beats));
            check("protocol_err pulses per burst", 32'(n_pe), 32'(n_pe_exp));
        end
        exp_bd   = 1'b0;
        exp_pe   = 1'b0;
        exp_done = 1'b0;

        if (!active && exp_q.size() > 0) begin
            cur      = exp_q.pop_front();
            active   = 1'b1;
            data_ph  = 1'b0;
            n_addr   = 0;
            n_bd     = 0;
            n_pe     = 0;
            n_pe_exp = 0;
            exp_tr   = 2'b00;
            exp_req  = 1'b1;
        end

        if (active) begin
            check("HTRANS", 32'(HTRANS), 32'(exp_tr));
            check("HBUSREQ", 32'(HBUSREQ), 32'(exp_req));
            check("HLOCK", 32'(HLOCK), 32'(exp_req && cur.lock));
            check("cmd_ready busy", 32'(cmd_ready), 32'(0));
            if (data_ph) begin
                if (HREADY) begin
                    exp_done = 1'b1;
                    active   = 1'b0;
                end
            end else if (exp_tr != 2'b00) begin
                if (HREADY) begin
                    n_addr++;
                    exp_bd = 1'b1;
                    if (HMASTER != 4'(ID)) begin
                        n_pe_exp++;
                        exp_pe = 1'b1;
                    end
                    if (n_addr == cur.beats) begin
                        data_ph = 1'b1;
                        exp_tr  = 2'b00;
                        exp_req = 1'b0;
                    end else if (!HGRANT) begin
                        exp_tr = 2'b00;
                    end else begin
                        exp_tr = 2'b11;
                    end
                end
            end else if (HGRANT && HREADY) begin
                exp_tr = 2'b10;
            end
        end else begin
            check("HTRANS idle", 32'(HTRANS), 32'(0));
            check("HBUSREQ idle", 32'(HBUSREQ), 32'(0));
            check("HLOCK idle", 32'(HLOCK), 32'(0));
            check("cmd_ready idle", 32'(cmd_ready), 32'(1));
        end
    endtask

    initial begin
        forever begin
            @(negedge HCLK);
            if (mon_en) mon_cycle();
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int beats_enc, input bit lock);
        int c = 0;
        @(posedge HCLK);
        #1;
        while (!cmd_ready && c < 3000) begin
            @(posedge HCLK);
            #1;
            c++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue: cmd_ready stayed 0 for %0d cycles", c);
            return;
        end
        cmd_valid = 1'b1;
        cmd_beats = 4'(beats_enc);
        cmd_lock  = lock;
        @(posedge HCLK);
        #1;
        cmd_valid = 1'b0;
        cmd_beats = 4'($urandom);
        cmd_lock  = 1'($urandom);
        exp_q.push_back('{beats: (beats_enc == 0) ? 16 : beats_enc, lock: lock});
    endtask

    task automatic wait_idle();
        int c = 0;
        while (mon_busy() && c < 3000) begin
            @(posedge HCLK);
            #1;
            c++;
        end
        if (mon_busy()) begin
            n_cmp++;
            n_err++;
            $display("FAIL burst completion: still busy after %0d cycles", c);
            mon_reset();
        end
    endtask

    // Drops grant or ready just as beat (after+1) is presented, holds it low, then restores.
    task automatic run_with_drop(input int beats, input bit drop_ready, input int after, input int hold);
        int held    = 0;
        bit dropped = 1'b0;
        issue(beats, 1'b0);
        for (int c = 0; c < 400 && mon_busy(); c++) begin
            @(posedge HCLK);
            #1;
            if (!dropped && n_addr == after && HTRANS != 2'b00) begin
                dropped = 1'b1;
                if (drop_ready) fix_ready = 1'b0;
                else            fix_grant = 1'b0;
            end else if (dropped && held < hold) begin
                held++;
                if (held == hold) begin
                    fix_ready = 1'b1;
                    fix_grant = 1'b1;
                end
            end
        end
        check(drop_ready ? "HREADY stall applied" : "grant drop applied", 32'(dropped), 32'(1));
        wait_idle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET    = 1'b1;
        cmd_valid = 1'b1;
        cmd_beats = 4'd3;
        cmd_lock  = 1'b1;
        mon_reset();

        // Reset held with a command offered: the controller must not leave IDLE.
        repeat (3) begin
            @(negedge HCLK);
            check("reset HBUSREQ", 32'(HBUSREQ), 32'(0));
            check("reset cmd_ready", 32'(cmd_ready), 32'(1));
        end
        @(posedge HCLK);
        #1;
        HRESET    = 1'b0;
        cmd_valid = 1'b0;
        @(posedge HCLK);
        @(negedge HCLK);
        check("post-reset cmd_ready", 32'(cmd_ready), 32'(1));
        check("post-reset HBUSREQ", 32'(HBUSREQ), 32'(0));
        check("post-reset HTRANS", 32'(HTRANS), 32'(0));
        check("post-reset pulses", 32'({HLOCK, beat_done, burst_done, protocol_err, timeout}), 32'(0));

        @(posedge HCLK);
        #1;
        mon_en = 1'b1;

        // Parked arbiter, 4 beats; 16 beats; single beat.
        issue(4, 1'b0);
        wait_idle();
        issue(0, 1'b0);
        wait_idle();
        issue(1, 1'b0);
        wait_idle();

        // Grant withdrawn after beat 3 for 5 cycles, then a 3-cycle HREADY stall mid-burst.
        run_with_drop(8, 1'b0, 2, 5);
        run_with_drop(6, 1'b1, 2, 3);

        // Locked burst while the arbiter reports another owner.
        fix_master = 4'(ID ^ 3);
        issue(4, 1'b1);
        wait_idle();
        fix_master = 4'(ID);

        // Randomised bus behaviour.
        grant_pct = 75;
        ready_pct = 70;
        wrong_pct = 15;
        env_rand  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bit lk;
            lk       = 1'($urandom);
            env_lock = lk;
            issue(int'($urandom_range(15)), lk);
            wait_idle();
        end
        env_rand = 1'b0;
        env_lock = 1'b0;

        // Reset in the middle of a 16-beat burst: no further beats and no burst_done.
        issue(0, 1'b0);
        repeat (5) begin
            @(posedge HCLK);
            #1;
        end
        mon_en = 1'b0;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        repeat (20) begin
            @(negedge HCLK);
            check("after abort", 32'({HTRANS, HBUSREQ, beat_done, burst_done}), 32'(0));
        end
        mon_reset();

`ifdef AHB_REQ_TIMEOUT_EN
        begin
            int req_cycles;
            bit seen;
            req_cycles = 0;
            seen       = 1'b0;
            fix_grant  = 1'b0;
            issue(3, 1'b0);
            exp_q.delete();
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge HCLK);
                if (timeout)      seen = 1'b1;
                else if (HBUSREQ) req_cycles++;
            end
            check("timeout pulse", 32'(seen), 32'(1));
            check("REQ cycles before timeout", 32'(req_cycles), 32'(64));
            check("HBUSREQ after timeout", 32'(HBUSREQ), 32'(0));
            check("cmd_ready after timeout", 32'(cmd_ready), 32'(1));
            fix_grant = 1'b1;
            mon_reset();
        end
`endif

        @(posedge HCLK);
        #1;
        mon_en = 1'b1;
        issue(2, 1'b1);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_master_req_ctrl.md
Name: ahb_master_req_ctrl

Overview:
Per-master bus-request front end that sits directly upstream of the 16-way AHB arbiter. It takes burst commands from local master logic and drives the arbiter-facing HBUSREQ/HLOCK for one master. It tracks grant/ownership from HGRANT, HREADY and HMASTER, and sequences HTRANS (NONSEQ/SEQ/IDLE) for the address phases, including re-arbitration when the grant is lost mid-burst. One instance is built per master (MASTER_ID 0..15).

Parameters:
MASTER_ID, 0, index of this master on the arbiter (0..15), compared against HMASTER.
TIMEOUT, 64, grant-wait cycle limit; used only when AHB_REQ_TIMEOUT_EN is defined.

Ports:
HCLK  in  1  bus clock; all logic on its rising edge.
HRESET  in  1  synchronous, active-high reset.
cmd_valid  in  1  burst command offered.
cmd_ready  out  1  controller idle and accepting a command.
cmd_beats  in  4  burst length; 1..15 as-is, 0 encodes 16.
cmd_lock  in  1  request a locked burst.
HBUSREQ  out  1  to the arbiter's HBUSREQx[MASTER_ID].
HLOCK  out  1  to the arbiter's HLOCKx[MASTER_ID].
HGRANT  in  1  from the arbiter's HGRANTx[MASTER_ID].
HREADY  in  1  shared transfer-done signal.
HMASTER  in  4  current bus owner reported by the arbiter.
HTRANS  out  2  00 IDLE, 10 NONSEQ, 11 SEQ (01 BUSY is never driven).
beat_done  out  1  one-cycle pulse per accepted address phase.
burst_done  out  1  one-cycle pulse when the final data phase completes.
protocol_err  out  1  one-cycle pulse when in ADDR and HMASTER != MASTER_ID.
timeout  out  1  one-cycle pulse on grant timeout (feature only; otherwise tied 0).

Behaviour:
- Reset and clocking:
  - Single clock HCLK; reset HRESET is synchronous, active-high.
  - State regs: fsm state, remaining[4:0], lock_q, first_q. Outputs are decoded from these registers, so there are no combinational paths from inputs to HBUSREQ, HLOCK or HTRANS.
  - With HRESET high at an edge: state=IDLE, remaining=0, lock_q=0.
  - After reset: cmd_ready=1; HBUSREQ, HLOCK, HTRANS, beat_done, burst_done, protocol_err and timeout are all 0.
  - Reset mid-burst aborts immediately. No further beats are issued and no burst_done is pulsed.
- IDLE:
  - cmd_ready=1, HBUSREQ=0, HTRANS=IDLE.
  - On cmd_valid: latch remaining = (cmd_beats==0 ? 16 : cmd_beats), lock_q=cmd_lock, first_q=1; go to REQ.
- REQ:
  - HBUSREQ=1, HLOCK=lock_q, HTRANS=IDLE.
  - At an edge with HGRANT && HREADY: go to ADDR (bus owned from the next cycle).
  - Otherwise stay in REQ.
- ADDR:
  - HBUSREQ=1, HLOCK=lock_q, HTRANS = first_q ? NONSEQ : SEQ.
  - At an edge with HREADY=1: the beat is accepted; beat_done pulses in the following cycle; remaining decrements; first_q clears.
  - If remaining becomes 0: go to DATA.
  - Else if HGRANT=0 at that same edge (grant withdrawn, possible only when lock_q=0): go to REQ with first_q=1, so the resumed beat uses NONSEQ.
  - HREADY=0 holds HTRANS and remaining unchanged.
  - protocol_err pulses when HMASTER != MASTER_ID during an ADDR cycle with HREADY=1; the beat is still counted.
- DATA:
  - HBUSREQ=0, HLOCK=0, HTRANS=IDLE.
  - On HREADY=1: burst_done pulses, then go to IDLE.
- Simultaneous events:
  - cmd_valid is ignored outside IDLE.
  - A single-beat burst goes REQ→ADDR→DATA→IDLE with exactly one NONSEQ.
  - Minimum latency from cmd_valid (arbiter parked on this master, HREADY=1) to the first NONSEQ is 2 cycles.

Optional Feature:
- AHB_REQ_TIMEOUT_EN defined:
  - A counter runs while in REQ and clears on leaving REQ.
  - When it reaches TIMEOUT: drop HBUSREQ, pulse timeout, go to IDLE; remaining burst beats are discarded.
- Undefined: no counter; REQ waits indefinitely; timeout output is 0.

Decomposition:
- Package ahb_req_pkg holds:
  - htrans_t enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11);
  - req_state_t enum (IDLE, REQ, ADDR, DATA);
  - constant MAX_BEATS=16.
- No sub-module: a single FSM plus counter.

Test Plan:
- Reset with cmd_valid=1 held high → no state change while reset is asserted; one cycle after release cmd_ready=1, HBUSREQ=0, HTRANS=00.
- cmd_beats=4, HGRANT=1, HREADY=1 → HTRANS sequence 10,11,11,11,00; four beat_done pulses; one burst_done; HBUSREQ low from the DATA cycle.
- cmd_beats=0 → exactly 16 address phases (1 NONSEQ + 15 SEQ).
- Unlocked 8-beat burst, HGRANT dropped after beat 3 and restored 5 cycles later → HBUSREQ stays high in REQ; resume with NONSEQ and 5 more beats; 8 beat_done pulses in total.
- HREADY=0 for 3 cycles in the middle of ADDR → HTRANS held steady; no beat_done; remaining unchanged.
- cmd_lock=1 with HMASTER forced to a different value → HLOCK=1 through ADDR; protocol_err pulses each affected beat. With AHB_REQ_TIMEOUT_EN defined and TIMEOUT=64, HGRANT held 0 → timeout pulse after 64 REQ cycles, then IDLE.
